// File: rtl/gshare_ctrl.sv
// gshare predictor controller: drives a dual-port counter SRAM (port 0 lookups,
// port 1 init and read-modify-write updates) and owns the speculative global history.
module gshare_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 16,
    parameter int GHR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid,
    output logic                  pred_ready,
    input  logic [31:0]           pred_pc,
    output logic                  resp_valid,
    output logic                  resp_taken,
    output logic [GHR_WIDTH-1:0]  resp_ghr,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [31:0]           upd_pc,
    input  logic [GHR_WIDTH-1:0]  upd_ghr,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    output logic [GHR_WIDTH-1:0]  ghr,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic                  web1,
    output logic [NUM_WMASKS-1:0] wmask1,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam int SLOT_W = GHR_WIDTH - ADDR_WIDTH;

    typedef enum logic [2:0] {S_INIT, S_INIT_CLR, S_IDLE, S_RMW, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] uaddr_q, uaddr_d;
    logic [SLOT_W-1:0]     uslot_q, uslot_d;
    logic                  utaken_q, utaken_d;
    logic                  rvld_q;
    logic [SLOT_W-1:0]     pslot_q;
    logic [GHR_WIDTH-1:0]  rghr_q;
    logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;

    logic [GHR_WIDTH-1:0]  pred_idx, upd_idx;
    logic                  pred_acc, upd_acc;
    logic [1:0]            cnt_old, cnt_new;
    logic                  unused;

    assign pred_idx = pred_pc[GHR_WIDTH+1:2] ^ ghr_q;
    assign upd_idx  = upd_pc[GHR_WIDTH+1:2] ^ upd_ghr;
    assign unused   = ^{pred_pc[31:GHR_WIDTH+2], pred_pc[1:0], upd_pc[31:GHR_WIDTH+2], upd_pc[1:0]};

    assign cnt_old = dout1[{uslot_q, 1'b0} +: 2];
    always_comb begin
        cnt_new = cnt_old;
        if (utaken_q && cnt_old != 2'b11)       cnt_new = cnt_old + 2'd1;
        else if (!utaken_q && cnt_old != 2'b00) cnt_new = cnt_old - 2'd1;
    end

    // Port 1 sequencing; all SRAM strobes are forced idle while reset is held
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        uaddr_d    = uaddr_q;
        uslot_d    = uslot_q;
        utaken_d   = utaken_q;
        csb1       = 1'b1;
        web1       = 1'b1;
        wmask1     = '0;
        addr1      = '0;
        din1       = '0;
        pred_ready = 1'b0;
        upd_ready  = 1'b0;
        upd_acc    = 1'b0;
        case (state_q)
            S_INIT: begin
                csb1   = 1'b0;
                web1   = 1'b0;
                addr1  = ptr_q;
                din1   = {NUM_WMASKS{2'b01}};
                wmask1 = '1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = S_INIT_CLR;
            end
            S_INIT_CLR: begin
                csb1    = 1'b0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                pred_ready = 1'b1;
                upd_ready  = 1'b1;
                if (upd_valid) begin
                    upd_acc  = 1'b1;
                    uaddr_d  = upd_idx[GHR_WIDTH-1:SLOT_W];
                    uslot_d  = upd_idx[SLOT_W-1:0];
                    utaken_d = upd_taken;
                    csb1     = 1'b0;
                    addr1    = upd_idx[GHR_WIDTH-1:SLOT_W];
                    state_d  = S_RMW;
                end
            end
            S_RMW: begin
                pred_ready = 1'b1;
                csb1       = 1'b0;
                web1       = 1'b0;
                addr1      = uaddr_q;
                wmask1     = NUM_WMASKS'(1) << uslot_q;
                din1       = DATA_WIDTH'(cnt_new) << {uslot_q, 1'b0};
                state_d    = S_DRAIN;
            end
            S_DRAIN: begin
                pred_ready = 1'b1;
                csb1       = 1'b0;
                addr1      = uaddr_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        if (!rst_n) begin
            csb1       = 1'b1;
            web1       = 1'b1;
            wmask1     = '0;
            pred_ready = 1'b0;
            upd_ready  = 1'b0;
            upd_acc    = 1'b0;
        end
    end

    assign pred_acc   = pred_valid & pred_ready;
    assign csb0       = ~pred_acc;
    assign web0       = 1'b1;
    assign wmask0     = '0;
    assign din0       = '0;
    assign addr0      = pred_idx[GHR_WIDTH-1:SLOT_W];
    assign resp_valid = rvld_q & rst_n;
    assign resp_taken = resp_valid & dout0[{pslot_q, 1'b1}];
    assign resp_ghr   = rghr_q;
    assign ghr        = rst_n ? ghr_q : '0;

    // Mispredict repair overrides the speculative shift from a same-cycle response
    always_comb begin
        ghr_d = ghr_q;
        if (upd_acc && upd_mispredict) ghr_d = {upd_ghr[GHR_WIDTH-2:0], upd_taken};
        else if (resp_valid)           ghr_d = {ghr_q[GHR_WIDTH-2:0], resp_taken};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            ptr_q    <= '0;
            uaddr_q  <= '0;
            uslot_q  <= '0;
            utaken_q <= 1'b0;
            rvld_q   <= 1'b0;
            pslot_q  <= '0;
            rghr_q   <= '0;
            ghr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            uaddr_q  <= uaddr_d;
            uslot_q  <= uslot_d;
            utaken_q <= utaken_d;
            rvld_q   <= pred_acc;
            pslot_q  <= pred_idx[SLOT_W-1:0];
            rghr_q   <= ghr_q;
            ghr_q    <= ghr_d;
        end
    end
endmodule
